state_encode_scheduler: RTL

Sequences the serial state encoder: decides when a new encoded frame is sent, freezes the state snapshot the encoder sees for the whole frame, and generates the encoder's enable pulse. Three request sources compete for the single encoder: host force, debounced state change and periodic refresh. Sits between the controller state register and the encoder's `state`/`enable` inputs; the encoder has no busy output, so occupancy is tracked here by cycle count.

---
 rtl/state_encode_scheduler_if.sv | 24 ++
 rtl/state_encode_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/state_encode_scheduler_if.sv
// rtl/state_encode_scheduler_if.sv - controller/encoder-side signal bundle for the frame scheduler
interface state_encode_scheduler_if #(
  parameter int STATE_LENGTH = 7
);
  logic [STATE_LENGTH-1:0] state;
  logic                    forceReq;
  logic                    refreshEn;
  logic [STATE_LENGTH-1:0] encState;
  logic                    encEnable;
  logic                    busy;
  logic [1:0]              lastReason;
  logic [7:0]              frameCount;
  logic [7:0]              forceDropCount;

  modport master (
    output state, forceReq, refreshEn,
    input  encState, encEnable, busy, lastReason, frameCount, forceDropCount
  );

  modport slave (
    input  state, forceReq, refreshEn,
    output encState, encEnable, busy, lastReason, frameCount, forceDropCount
  );
endinterface

// File: rtl/state_encode_scheduler.sv
// rtl/state_encode_scheduler.sv - arbitrates force/change/refresh requests into encoder frames
module state_encode_scheduler #(
  parameter int STATE_LENGTH   = 7,
  parameter int FRAME_CYCLES   = 29,
  parameter int GAP_CYCLES     = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int REFRESH_PERIOD = 1000
) (
  input logic                    clk,
  input logic                    resetN,
  state_encode_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT, GAP} fsm_t;

  localparam logic [15:0] FRAME_LAST  = 16'(FRAME_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(REFRESH_PERIOD - 1);
  localparam logic [3:0]  STABLE_MAX  = 4'(STABLE_CYCLES);

  fsm_t                    fsm_q, fsm_d;
  logic [15:0]             cyc_q, cyc_d;
  logic                    start;
  logic [1:0]              reason_d;

  logic [STATE_LENGTH-1:0] prev_q, last_sent_q, enc_q;
  logic [3:0]              stable_q, stable_d;
  logic                    change_pending;
  logic                    force_pend_q, refresh_pend_q;
  logic [15:0]             timer_q;
  logic                    enable_q, busy_q;
  logic [1:0]              reason_q;
  logic [7:0]              frames_q, drops_q;

  // The count includes the sample taken on this edge, so a step seen at edge k
  // becomes eligible at edge k+STABLE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    if (bus.state != prev_q)
      stable_d = '0;
    else if (stable_q != STABLE_MAX)
      stable_d = stable_q + 4'd1;
  end

  assign change_pending = (stable_d == STABLE_MAX) && (bus.state != last_sent_q);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fsm_q <= IDLE;
      cyc_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cyc_q <= cyc_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    cyc_d    = cyc_q;
    start    = 1'b0;
    reason_d = force_pend_q ? 2'b11 : (change_pending ? 2'b01 : 2'b10);
    case (fsm_q)
      IDLE: begin
        if (force_pend_q || change_pending || refresh_pend_q) begin
          fsm_d = LOAD;
          start = 1'b1;
        end
      end
      LOAD: begin
        fsm_d = PULSE;
        cyc_d = '0;
      end
      PULSE: begin
        if (cyc_q == 16'd1) begin
          fsm_d = WAIT;
          cyc_d = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      WAIT: begin
        if (cyc_q == FRAME_LAST) begin
          fsm_d = GAP;
          cyc_d = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      GAP: begin
        if (cyc_q == GAP_LAST) begin
          fsm_d = IDLE;
          cyc_d = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_q         <= '0;
      stable_q       <= '0;
      last_sent_q    <= '0;
      enc_q          <= '0;
      force_pend_q   <= 1'b0;
      refresh_pend_q <= 1'b0;
      timer_q        <= '0;
      enable_q       <= 1'b0;
      busy_q         <= 1'b0;
      reason_q       <= '0;
      frames_q       <= '0;
      drops_q        <= '0;
    end else begin
      prev_q   <= bus.state;
      stable_q <= stable_d;
      busy_q   <= (fsm_d != IDLE);
      enable_q <= (fsm_d == PULSE);

      if (start) begin
        enc_q       <= bus.state;
        last_sent_q <= bus.state;
        reason_q    <= reason_d;
        frames_q    <= frames_q + 8'd1;
      end

      if (bus.forceReq && force_pend_q && (drops_q != 8'hFF))
        drops_q <= drops_q + 8'd1;

      // A force arriving on the LOAD edge survives for the next frame.
      if (start)
        force_pend_q <= bus.forceReq;
      else if (bus.forceReq)
        force_pend_q <= 1'b1;

      if (start) begin
        timer_q        <= '0;
        refresh_pend_q <= 1'b0;
      end else if (!bus.refreshEn) begin
        timer_q <= '0;
      end else if (timer_q != PERIOD_LAST) begin
        timer_q <= timer_q + 16'd1;
        if (timer_q + 16'd1 == PERIOD_LAST)
          refresh_pend_q <= 1'b1;
      end
    end
  end

  assign bus.encState       = enc_q;
  assign bus.encEnable      = enable_q;
  assign bus.busy           = busy_q;
  assign bus.lastReason     = reason_q;
  assign bus.frameCount     = frames_q;
  assign bus.forceDropCount = drops_q;
endmodule
